register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, register and port data width.
REQ-002 Parameter ADDR_WIDTH, default 6, address width of all register-file ports.
REQ-003 Parameter NUM_REGS, default 32, number of implemented registers (addresses 0..NUM_REGS-1).
REQ-004 Port clock, input, 1, the single clock; all state on rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port register_file_read_address_1, input, ADDR_WIDTH, read port 1 address.
REQ-007 Port register_file_read_address_2, input, ADDR_WIDTH, read port 2 address.
REQ-008 Port register_file_read_value_1, output, DATA_WIDTH, read port 1 data.
REQ-009 Port register_file_read_value_2, output, DATA_WIDTH, read port 2 data.
REQ-010 Port register_file_write_address, input, ADDR_WIDTH, write address.
REQ-011 Port register_file_write_value, input, DATA_WIDTH, write data.
REQ-012 Port register_file_write_enable, input, 1, write strobe.
REQ-013 Port dump_start, input, 1, request to stream all registers out.
REQ-014 Port dump_valid, output, 1, dump_index/dump_value hold a valid entry.
REQ-015 Port dump_ready, input, 1, consumer accepts the current entry.
REQ-016 Port dump_index, output, ADDR_WIDTH, index of the presented entry.
REQ-017 Port dump_value, output, DATA_WIDTH, value of the presented entry.
REQ-018 Port dump_done, output, 1, one-cycle pulse after last entry accepted.
REQ-019 Port write_count, output, 32, number of committed writes.

Function
REQ-020 Reads SHALL be combinational; read of address 0 or address >= NUM_REGS SHALL return 0.
REQ-021 A write SHALL commit at the rising edge when write_enable=1 and 0 < write_address < NUM_REGS; all other writes SHALL be ignored.
REQ-022 Same-cycle bypass: when a committing write targets a read port's address, that port SHALL return write_value in that cycle.
REQ-023 write_count SHALL increment by 1 per committed write and saturate at 32'hFFFFFFFF.
REQ-024 Dump FSM states SHALL be DUMP_IDLE, DUMP_ACTIVE, DUMP_DONE.
REQ-025 DUMP_IDLE: dump_start=1 SHALL move to DUMP_ACTIVE next cycle with dump_valid=1, dump_index=0, dump_value=0.
REQ-026 DUMP_ACTIVE: on dump_valid&dump_ready, dump_index SHALL increment and dump_value SHALL load the next register, including bypass of a same-cycle committing write.
REQ-027 While dump_valid=1 and dump_ready=0, dump_index and dump_value SHALL hold stable regardless of writes (snapshot at load).
REQ-028 Acceptance of index NUM_REGS-1 SHALL move to DUMP_DONE, dropping dump_valid; DUMP_DONE SHALL assert dump_done for exactly one cycle then return to DUMP_IDLE.
REQ-029 dump_start SHALL be ignored outside DUMP_IDLE; normal reads/writes SHALL be unaffected by dump activity.

Reset
REQ-030 reset=0 SHALL asynchronously clear all registers, write_count, dump_index, dump_value to 0, dump_valid and dump_done to 0, and force DUMP_IDLE, including mid-dump.
REQ-031 Writes and dump_start SHALL have no effect while reset=0.

Structure
REQ-032 Package register_file_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH/NUM_REGS defaults and the dump state enum.
REQ-033 The dump sequencer SHALL be one sub-module, register_file_dump_fsm; storage, bypass and counter stay in the top.

Verification
REQ-034 Write r5=0x12345678, next cycle read port 1 addr 5 -> 0x12345678; write_count=1.
REQ-035 Write r0=0xFFFFFFFF and addr 40=0x1 -> reads return 0, write_count unchanged.
REQ-036 Write r7=0xA5A5A5A5 while port 2 reads addr 7 same cycle -> port 2 shows 0xA5A5A5A5 that cycle.
REQ-037 Load r1..r31 = index*3, dump_start with dump_ready=1 -> 32 consecutive entries (0,0),(1,3)..(31,93), dump_done one cycle after index 31.
REQ-038 Dump with dump_ready=0 at index 4 while writing r4=0xDEAD -> dump_value holds 12 until accepted; later read of r4 -> 0xDEAD.
REQ-039 Assert reset=0 at dump index 10 -> dump_valid=0 immediately, all reads 0, write_count=0, new dump_start restarts at index 0.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared defaults and the dump sequencer state encoding for the register file.
package register_file_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 6;
   localparam int DEFAULT_NUM_REGS   = 32;

   typedef enum logic [1:0] {
      DUMP_IDLE   = 2'd0,
      DUMP_ACTIVE = 2'd1,
      DUMP_DONE   = 2'd2
   } dump_state_t;

endpackage

// File: rtl/register_file_dump_fsm.sv
// Streams every register out over a valid/ready channel, one entry per accepted beat.
module register_file_dump_fsm
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  dump_start,
   input  logic                  dump_ready,
   input  logic [DATA_WIDTH-1:0] dump_read_value,
   output logic [ADDR_WIDTH-1:0] dump_read_address,
   output logic                  dump_valid,
   output logic [ADDR_WIDTH-1:0] dump_index,
   output logic [DATA_WIDTH-1:0] dump_value,
   output logic                  dump_done,
   output dump_state_t           dump_state
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

   dump_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] index_q, index_d;
   logic [DATA_WIDTH-1:0] value_q, value_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;

   // Handshake: an entry transfers on a rising edge where dump_valid & dump_ready;
   // while valid is high and ready low, index and value are frozen snapshots.
   assign dump_read_address = index_q + ADDR_WIDTH'(1);

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      value_d = value_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      case (state_q)
         DUMP_IDLE: begin
            if (dump_start) begin
               state_d = DUMP_ACTIVE;
               valid_d = 1'b1;
               index_d = '0;
               value_d = '0;
            end
         end
         DUMP_ACTIVE: begin
            if (dump_ready) begin
               if (index_q == LAST_IDX) begin
                  state_d = DUMP_DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  index_d = dump_read_address;
                  value_d = dump_read_value;
               end
            end
         end
         DUMP_DONE: state_d = DUMP_IDLE;
         default:   state_d = DUMP_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= DUMP_IDLE;
         index_q <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         value_q <= value_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign dump_valid = valid_q;
   assign dump_index = index_q;
   assign dump_value = value_q;
   assign dump_done  = done_q;
   assign dump_state = state_q;

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file with write bypass, a write counter and a dump streamer.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int NUM_REGS   = DEFAULT_NUM_REGS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] register_file_read_address_1,
   input  logic [ADDR_WIDTH-1:0] register_file_read_address_2,
   output logic [DATA_WIDTH-1:0] register_file_read_value_1,
   output logic [DATA_WIDTH-1:0] register_file_read_value_2,
   input  logic [ADDR_WIDTH-1:0] register_file_write_address,
   input  logic [DATA_WIDTH-1:0] register_file_write_value,
   input  logic                  register_file_write_enable,
   input  logic                  dump_start,
   output logic                  dump_valid,
   input  logic                  dump_ready,
   output logic [ADDR_WIDTH-1:0] dump_index,
   output logic [DATA_WIDTH-1:0] dump_value,
   output logic                  dump_done,
   output logic [31:0]           write_count,
   output dump_state_t           dump_state
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [31:0]           write_count_q, write_count_d;
   logic                  write_commit;
   logic [ADDR_WIDTH-1:0] dump_read_address;
   logic [DATA_WIDTH-1:0] dump_read_value;

   // Register 0 is hard-wired to zero, so it is never a legal write or read target.
   function automatic logic addr_implemented(input logic [ADDR_WIDTH-1:0] addr);
      return (addr != '0) && ({1'b0, addr} < NUM_REGS_W);
   endfunction

   assign write_commit = register_file_write_enable &&
                         addr_implemented(register_file_write_address);

   function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] addr);
      if (write_commit && (addr == register_file_write_address))
         return register_file_write_value;
      else if (addr_implemented(addr))
         return regs_q[addr[IDX_W-1:0]];
      else
         return '0;
   endfunction

   assign register_file_read_value_1 = read_reg(register_file_read_address_1);
   assign register_file_read_value_2 = read_reg(register_file_read_address_2);
   assign dump_read_value            = read_reg(dump_read_address);

   always_comb begin
      regs_d = regs_q;
      if (write_commit)
         regs_d[register_file_write_address[IDX_W-1:0]] = register_file_write_value;
   end

   always_comb begin
      write_count_d = write_count_q;
      if (write_commit && (write_count_q != 32'hFFFF_FFFF))
         write_count_d = write_count_q + 32'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
         write_count_q <= '0;
      end else begin
         regs_q        <= regs_d;
         write_count_q <= write_count_d;
      end
   end

   assign write_count = write_count_q;

   register_file_dump_fsm #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_dump_fsm (
      .clock             (clock),
      .reset             (reset),
      .dump_start        (dump_start),
      .dump_ready        (dump_ready),
      .dump_read_value   (dump_read_value),
      .dump_read_address (dump_read_address),
      .dump_valid        (dump_valid),
      .dump_index        (dump_index),
      .dump_value        (dump_value),
      .dump_done         (dump_done),
      .dump_state        (dump_state)
   );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed reads/writes plus scoreboarded dumps.
module tb_register_file;
   import register_file_pkg::*;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int NR = 32;

   logic          clock;
   logic          reset;
   logic [AW-1:0] ra1, ra2, wa;
   logic [DW-1:0] rv1, rv2, wv;
   logic          we;
   logic          dump_start, dump_valid, dump_ready, dump_done;
   logic [AW-1:0] dump_index;
   logic [DW-1:0] dump_value;
   logic [31:0]   write_count;
   dump_state_t   dump_state;

   logic [AW+DW-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   register_file dut (
      .clock                        (clock),
      .reset                        (reset),
      .register_file_read_address_1 (ra1),
      .register_file_read_address_2 (ra2),
      .register_file_read_value_1   (rv1),
      .register_file_read_value_2   (rv2),
      .register_file_write_address  (wa),
      .register_file_write_value    (wv),
      .register_file_write_enable   (we),
      .dump_start                   (dump_start),
      .dump_valid                   (dump_valid),
      .dump_ready                   (dump_ready),
      .dump_index                   (dump_index),
      .dump_value                   (dump_value),
      .dump_done                    (dump_done),
      .write_count                  (write_count),
      .dump_state                   (dump_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic write_reg(input logic [AW-1:0] addr, input logic [DW-1:0] val);
      @(negedge clock);
      we = 1'b1;
      wa = addr;
      wv = val;
      @(posedge clock);
      #1;
      we = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
      @(negedge clock);
      ra1 = addr;
      ra2 = addr;
      #1;
      check({tag, "_p1"}, 64'(rv1), 64'(exp));
      check({tag, "_p2"}, 64'(rv2), 64'(exp));
   endtask

   task automatic compare_entry();
      if (exp_q.size() == 0)
         check("dump_extra_entry", 64'(dump_index), 64'hFFFF);
      else
         check("dump_entry", 64'({dump_index, dump_value}), 64'(exp_q.pop_front()));
   endtask

   task automatic check_done_pulse();
      @(negedge clock);
      dump_start = 1'b0;
      #1;
      check("dump_done_pulse", 64'({dump_done, dump_valid}), 64'b10);
      check("dump_state_done", 64'(dump_state), 64'(DUMP_DONE));
      @(negedge clock);
      #1;
      check("dump_done_clear", 64'({dump_done, dump_valid}), 64'b00);
      check("dump_state_idle", 64'(dump_state), 64'(DUMP_IDLE));
      check("dump_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // Starts a dump and accepts entries until NR are seen or the cycle budget runs out.
   task automatic run_dump(input int budget, input bit rand_ready);
      int seen;
      seen = 0;
      @(negedge clock);
      dump_start = 1'b1;
      dump_ready = 1'b1;
      for (int cyc = 0; cyc < budget && seen < NR; cyc++) begin
         @(negedge clock);
         dump_start = 1'b0;
         #1;
         dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (dump_valid && dump_ready) begin
            compare_entry();
            seen++;
         end
      end
      check("dump_entry_count", 64'(seen), 64'(NR));
      check_done_pulse();
   endtask

   initial begin
      int  seen;
      int  stall;
      bit  fin;

      reset = 1'b0;
      ra1 = '0; ra2 = '0; wa = '0; wv = '0; we = 1'b0;
      dump_start = 1'b0; dump_ready = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      check("reset_dump_valid", 64'(dump_valid), 64'd0);
      check("reset_dump_done", 64'(dump_done), 64'd0);
      check("reset_write_count", 64'(write_count), 64'd0);
      check("reset_state", 64'(dump_state), 64'(DUMP_IDLE));
      @(negedge clock);
      reset = 1'b1;

      // Basic write then read.
      write_reg(6'd5, 32'h1234_5678);
      read_check("read_r5", 6'd5, 32'h1234_5678);
      check("count_after_r5", 64'(write_count), 64'd1);

      // Writes to r0 and out-of-range addresses are dropped.
      write_reg(6'd0, 32'hFFFF_FFFF);
      write_reg(6'd40, 32'h1);
      read_check("read_r0", 6'd0, 32'h0);
      read_check("read_a40", 6'd40, 32'h0);
      check("count_ignored", 64'(write_count), 64'd1);

      // Disabled write does nothing.
      @(negedge clock);
      we = 1'b0; wa = 6'd6; wv = 32'h5555_5555;
      @(posedge clock);
      read_check("read_r6_nowe", 6'd6, 32'h0);

      // Same-cycle bypass on port 2.
      @(negedge clock);
      ra1 = 6'd5; ra2 = 6'd7;
      we = 1'b1; wa = 6'd7; wv = 32'hA5A5_A5A5;
      #1;
      check("bypass_p2", 64'(rv2), 64'hA5A5_A5A5);
      check("bypass_p1_other", 64'(rv1), 64'h1234_5678);
      @(posedge clock);
      #1;
      we = 1'b0;
      check("count_after_r7", 64'(write_count), 64'd2);

      // Full dump with ready held high: 32 back-to-back entries.
      for (int i = 1; i < NR; i++)
         write_reg(AW'(i), DW'(i * 3));
      check("count_after_load", 64'(write_count), 64'd33);
      exp_q.delete();
      for (int i = 0; i < NR; i++)
         exp_q.push_back({AW'(i), DW'(i * 3)});
      run_dump(NR, 1'b0);

      // Dump with a stall at index 4, a write to r4 during the stall, and a write
      // to r9 in the same cycle index 8 is accepted; dump_start held high throughout.
      exp_q.delete();
      for (int i = 0; i < NR; i++)
         exp_q.push_back({AW'(i), (i == 9) ? 32'h9999 : DW'(i * 3)});
      @(negedge clock);
      dump_start = 1'b1;
      dump_ready = 1'b1;
      seen = 0;
      stall = 0;
      fin = 1'b0;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         @(negedge clock);
         we = 1'b0;
         #1;
         if (dump_valid) begin
            if (dump_index == 6'd4 && stall < 4) begin
               dump_ready = 1'b0;
               if (stall == 0) begin
                  we = 1'b1; wa = 6'd4; wv = 32'hDEAD;
               end
               check("dump_hold", 64'({dump_index, dump_value}), 64'({6'd4, 32'd12}));
               stall++;
            end else begin
               dump_ready = (dump_index == 6'd8) ? 1'b1 : 1'($urandom_range(0, 1));
               if (dump_index == 6'd8) begin
                  we = 1'b1; wa = 6'd9; wv = 32'h9999;
               end
               if (dump_ready) begin
                  compare_entry();
                  seen++;
                  if (dump_index == AW'(NR - 1))
                     fin = 1'b1;
               end
            end
         end
      end
      check("stall_dump_count", 64'(seen), 64'(NR));
      check_done_pulse();
      we = 1'b0;
      read_check("read_r4_after", 6'd4, 32'hDEAD);
      read_check("read_r9_after", 6'd9, 32'h9999);
      check("count_after_dump", 64'(write_count), 64'd35);

      // Reset in the middle of a dump at index 10.
      @(negedge clock);
      dump_start = 1'b1;
      dump_ready = 1'b1;
      fin = 1'b0;
      for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
         @(negedge clock);
         dump_start = 1'b0;
         #1;
         if (dump_valid && dump_index == 6'd10) begin
            reset = 1'b0;
            ra1 = 6'd5; ra2 = 6'd9;
            #1;
            fin = 1'b1;
         end
      end
      check("reset_reached_idx10", 64'(fin), 64'd1);
      check("midreset_valid", 64'(dump_valid), 64'd0);
      check("midreset_rv1", 64'(rv1), 64'd0);
      check("midreset_rv2", 64'(rv2), 64'd0);
      check("midreset_count", 64'(write_count), 64'd0);
      check("midreset_index", 64'({dump_index, dump_value}), 64'd0);
      @(negedge clock);
      we = 1'b1; wa = 6'd3; wv = 32'h3333; dump_start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      we = 1'b0; dump_start = 1'b0;
      #1;
      check("inreset_state", 64'({dump_valid, 2'(dump_state)}), 64'd0);
      reset = 1'b1;
      read_check("read_r3_after_reset", 6'd3, 32'h0);
      check("count_after_reset", 64'(write_count), 64'd0);
      check("idle_after_reset", 64'(dump_valid), 64'd0);

      exp_q.delete();
      for (int i = 0; i < NR; i++)
         exp_q.push_back({AW'(i), DW'(0)});
      run_dump(300, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
